redmule_tcdm_responder: RTL and testbench
=========================================

# redmule_tcdm_responder

Synthesizable TCDM responder (memory-side end of the HCI core protocol) used as the downstream target of RedMulE's TCDM path in block-level benches and standalone FPGA builds. It accepts requests on an `hci_core_intf.target` port, performs byte-enabled writes and reads on a single-bank word array, and returns read responses in order after a fixed, configurable latency. A response FIFO with credit-based grant throttling honours `r_ready` backpressure without dropping data.

## Interface
- `HCI_SIZE_PARAM(tcdm)`, `'0`: HCI size struct. Provides AW, DW, UW, IW; EW/EHW are carried but unused.
- `NumWords`, `1024`: depth of the word array. Power of two, ≥2.
- `RespLatency`, `1`: cycles from read grant to earliest `r_valid`. Integer ≥1.
- `RespFifoDepth`, `4`: maximum outstanding reads, counting pipeline and FIFO. ≥`RespLatency`.
- `clk_i`  in  1  single clock. All state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tcdm_target`  target  hci_core_intf  request and response channels.
- `outstanding_o`  out  $clog2(RespFifoDepth+1)  reads granted but not yet popped.

## Operation
- Request handshake: a request is accepted in cycle T when `req && gnt`.
- `wen=1` is a read; `wen=0` is a write.
- Write grant: `gnt = req` when `wen=0`. Writes are never throttled and produce no response.
- Read grant: `gnt = req && (outstanding < RespFifoDepth)`, evaluated on the registered counter. A pop in the same cycle does not free a credit until T+1.
- Word index is `add[$clog2(DW/8) +: $clog2(NumWords)]`.
  - Low byte-offset bits are ignored.
  - Upper bits are ignored, so the address wraps modulo NumWords×DW/8.
- Write: for each byte i with `be[i]=1`, `mem[idx][8i+:8] <= data[8i+:8]` at the grant edge. Bytes with `be[i]=0` are unchanged.
- Read data is sampled from the array at the grant edge.
  - A write granted in T is visible to a read granted in T+1 or later.
  - Only one request exists per cycle, so there is no same-cycle read/write conflict.
- Response path:
  - A `RespLatency-1` stage delay line carries {data, id, user} with a valid bit.
  - The delay line feeds a fall-through FIFO of depth `RespFifoDepth`.
  - Credit throttling guarantees the FIFO never overflows.
- Response outputs:
  - `r_valid` = FIFO not empty.
  - `r_data`, `r_id`, `r_user` come from the FIFO head. `r_id`/`r_user` echo the request's `id`/`user`.
  - `r_opc=0`, `r_ecc='0`, `r_evalid='0`, `egnt=0`.
  - `r_eready` and `ereq` are ignored.
- Pop occurs on `r_valid && r_ready`. Responses are strictly in grant order.
- Outstanding counter:
  - Increments on a read grant and decrements on a pop.
  - A simultaneous grant and pop leaves it unchanged.
  - `outstanding_o` is the registered counter.
- Array contents are not reset. A read of an unwritten word returns X in simulation.

## Timing
- Values during and after reset:
  - `gnt=0` (combinational on `req`, forced low while `rst_i=1`).
  - `r_valid=0`, `outstanding_o=0`.
  - Delay line and FIFO are empty.
  - `r_data`, `r_id` and `r_user` are don't-care while `r_valid=0`.
- Read latency: a read granted in T with an empty FIFO and `r_ready=1` gives `r_valid=1` in T+RespLatency, and it pops the same cycle.
- Throughput: one read per cycle is sustained when `r_ready` is held high and `RespFifoDepth ≥ RespLatency+1`. At equality with RespLatency there is one bubble per RespLatency grants.
- Backpressure: when `r_ready=0`, `r_valid` and the head payload are held stable until popped.
- Reset mid-operation: asserting `rst_i` in cycle T discards all in-flight and queued responses. From T+1 `r_valid=0` and `outstanding_o=0`, and no stale response ever appears. Array contents are retained.
- Full boundary: with `outstanding_o==RespFifoDepth`, a read `req` sees `gnt=0` while a write `req` sees `gnt=1`. After a pop in T, a read can be granted in T+1.
- Empty boundary: no `r_valid` glitch when the FIFO is empty and the delay line delivers its output in the same cycle. The response falls through combinationally into that cycle's `r_valid`.

## Test plan
- Single read, RespLatency=1:
  - Stimulus: write 0xDEADBEEF to add 0x10 with be=0xF, then read add 0x10 with id=3.
  - Required response: `r_valid` one cycle after the read grant, `r_data=0xDEADBEEF`, `r_id=3`.
- Byte enables:
  - Stimulus: write 0x11223344 with be=0xF, then write 0xAABBCCDD with be=0x5, then read.
  - Required response: 0x11BB33DD.
- Backpressure, RespFifoDepth=4, RespLatency=2:
  - Stimulus: `r_ready=0` with 6 back-to-back reads.
  - Required response: the first 4 are granted, `gnt=0` on the 5th, and `outstanding_o=4`.
  - Then raise `r_ready`: 4 responses appear in order and the 5th read is granted the cycle after the first pop.
- Random traffic:
  - Stimulus: 10k mixed reads and writes with random `r_ready`.
  - Required response: the scoreboard shows in-order, bit-exact data; `outstanding_o` never exceeds 4; no response for any write.
- Reset mid-burst:
  - Stimulus: 3 reads outstanding, then `rst_i` pulsed for 1 cycle.
  - Required response: `r_valid=0` and `outstanding_o=0` the next cycle, and no late responses in the following 10 cycles.
  - A subsequent read still returns the pre-reset written data.
- Address wrap, NumWords=1024, DW=32:
  - Stimulus: write 0xCAFE0001 to add 0x1000, then read add 0x0.
  - Required response: 0xCAFE0001. A read of add 0x3 also returns 0xCAFE0001.

Source files
------------

// File: rtl/redmule_tcdm_responder_if.sv
// HCI core protocol bundle between a TCDM initiator and a memory-side target.
// Request fields flow initiator->target; r_* response fields flow back.
interface hci_core_intf #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned BW  = 8,
  parameter int unsigned UW  = 1,
  parameter int unsigned IW  = 8,
  parameter int unsigned EW  = 1,
  parameter int unsigned EHW = 1
);
  logic               req;
  logic               gnt;
  logic [AW-1:0]      add;
  logic               wen;
  logic [DW-1:0]      data;
  logic [DW/BW-1:0]   be;
  logic               r_ready;
  logic [UW-1:0]      user;
  logic [IW-1:0]      id;
  logic [DW-1:0]      r_data;
  logic               r_valid;
  logic               r_opc;
  logic [UW-1:0]      r_user;
  logic [IW-1:0]      r_id;
  logic [EW-1:0]      ecc;
  logic [EW-1:0]      r_ecc;
  logic [EHW-1:0]     ereq;
  logic [EHW-1:0]     egnt;
  logic [EHW-1:0]     r_evalid;
  logic [EHW-1:0]     r_eready;

  modport initiator (
    output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    input  gnt, r_data, r_valid, r_opc, r_user, r_id, r_ecc, egnt, r_evalid
  );

  modport target (
    input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    output gnt, r_data, r_valid, r_opc, r_user, r_id, r_ecc, egnt, r_evalid
  );
endinterface

// File: rtl/redmule_tcdm_responder.sv
// TCDM target: single-bank byte-enabled word array answering reads in order after a fixed latency.
// Read grants are credit-throttled so the fall-through response FIFO never overflows under r_ready backpressure.

module redmule_tcdm_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [Width-1:0] in_dat,
  output logic             out_vld,
  output logic [Width-1:0] out_dat,
  input  logic             out_rdy
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] store [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count == '0);
  assign out_vld = in_vld || !empty;
  assign out_dat = empty ? in_dat : store[rd_ptr];
  // An arrival into an empty FIFO that is consumed at once never touches storage.
  assign push    = in_vld && !(empty && out_rdy);
  assign pop     = out_rdy && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module redmule_tcdm_responder #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned UW            = 1,
  parameter int unsigned IW            = 8,
  parameter int unsigned EW            = 1,
  parameter int unsigned EHW           = 1,
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned RespLatency   = 1,
  parameter int unsigned RespFifoDepth = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  hci_core_intf.target                         tcdm_target,
  output logic [$clog2(RespFifoDepth+1)-1:0]   outstanding_o
);
  localparam int unsigned BeW  = DW / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned PayW = DW + IW + UW;
  localparam int unsigned CntW = $clog2(RespFifoDepth + 1);

  logic [DW-1:0]          mem [NumWords];
  logic [IdxW-1:0]        idx;
  logic                   credit_ok;
  logic                   gnt;
  logic                   rd_gnt;
  logic                   wr_gnt;
  logic                   pop;
  logic                   rsp_vld;
  logic [CntW-1:0]        outstanding;
  logic [RespLatency-1:0] pipe_vld;
  logic [PayW-1:0]        pipe_dat [RespLatency];
  logic [PayW-1:0]        head_dat;
  logic                   unused_inputs;

  assign idx       = tcdm_target.add[OffW +: IdxW];
  // Credit check uses the registered count, so a pop frees a slot one cycle later.
  assign credit_ok = (outstanding < CntW'(RespFifoDepth));
  assign gnt       = !rst_i && tcdm_target.req && (!tcdm_target.wen || credit_ok);
  assign rd_gnt    = gnt && tcdm_target.wen;
  assign wr_gnt    = gnt && !tcdm_target.wen;

  always_ff @(posedge clk_i) begin
    if (wr_gnt) begin
      for (int i = 0; i < BeW; i++) begin
        if (tcdm_target.be[i]) begin
          mem[idx][8*i +: 8] <= tcdm_target.data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_gnt;
      for (int s = 1; s < RespLatency; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_gnt) begin
      pipe_dat[0] <= {mem[idx], tcdm_target.id, tcdm_target.user};
    end
    for (int s = 1; s < RespLatency; s++) begin
      pipe_dat[s] <= pipe_dat[s-1];
    end
  end

  redmule_tcdm_fifo #(
    .Width (PayW),
    .Depth (RespFifoDepth)
  ) i_resp_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .in_vld  (pipe_vld[RespLatency-1]),
    .in_dat  (pipe_dat[RespLatency-1]),
    .out_vld (rsp_vld),
    .out_dat (head_dat),
    .out_rdy (tcdm_target.r_ready)
  );

  assign pop = rsp_vld && tcdm_target.r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (rd_gnt && !pop) begin
      outstanding <= outstanding + CntW'(1);
    end else if (!rd_gnt && pop) begin
      outstanding <= outstanding - CntW'(1);
    end
  end

  assign outstanding_o = outstanding;

  assign tcdm_target.gnt      = gnt;
  assign tcdm_target.r_valid  = rsp_vld;
  assign tcdm_target.r_data   = head_dat[PayW-1 -: DW];
  assign tcdm_target.r_id     = head_dat[UW +: IW];
  assign tcdm_target.r_user   = head_dat[UW-1:0];
  assign tcdm_target.r_opc    = 1'b0;
  assign tcdm_target.r_ecc    = {EW{1'b0}};
  assign tcdm_target.r_evalid = {EHW{1'b0}};
  assign tcdm_target.egnt     = {EHW{1'b0}};

  assign unused_inputs = ^{tcdm_target.add, tcdm_target.ecc, tcdm_target.ereq, tcdm_target.r_eready};
endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Bench for redmule_tcdm_responder: queue-based reference model checked every cycle plus directed literal checks.
module tb_redmule_tcdm_responder;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int NW = 1024;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [2:0] outstanding;

  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(2), .IW(8), .EW(1), .EHW(1)) tcdm ();

  redmule_tcdm_responder #(
    .AW(32), .DW(32), .UW(2), .IW(8), .EW(1), .EHW(1),
    .NumWords(NW), .RespLatency(L), .RespFifoDepth(D)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .tcdm_target   (tcdm),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference model: word array plus queue of pending responses with their due cycle.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic [7:0]  id;
    logic [1:0]  user;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mmem [NW];
  int          cyc   = 0;
  bit          armed = 0;
  bit          m_gnt;
  bit          m_vld;
  int          w;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % NW);
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].due <= cyc);
  endfunction

  function automatic bit exp_gnt();
    return !rst_i && tcdm.req && (!tcdm.wen || q.size() < D);
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      q.delete();
      armed = 1;
    end else begin
      m_gnt = exp_gnt();
      if (exp_valid() && tcdm.r_ready) void'(q.pop_front());
      if (m_gnt && tcdm.wen) begin
        q.push_back('{cyc + L, mmem[widx(tcdm.add)], tcdm.id, tcdm.user});
      end else if (m_gnt) begin
        w = widx(tcdm.add);
        for (int b = 0; b < 4; b++)
          if (tcdm.be[b]) mmem[w][8*b +: 8] = tcdm.data[8*b +: 8];
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst_i) begin
      chk("gnt_in_reset", tcdm.gnt, 0);
    end else if (armed) begin
      m_vld = exp_valid();
      chk("gnt", tcdm.gnt, exp_gnt());
      chk("r_valid", tcdm.r_valid, m_vld);
      chk("outstanding", outstanding, q.size());
      chk("outstanding_le_depth", outstanding <= 3'd4, 1);
      if (m_vld) begin
        chk("r_data", tcdm.r_data, q[0].data);
        chk("r_id", tcdm.r_id, q[0].id);
        chk("r_user", tcdm.r_user, q[0].user);
      end
      chk("r_opc", tcdm.r_opc, 0);
      chk("egnt", tcdm.egnt, 0);
      chk("r_evalid", tcdm.r_evalid, 0);
      chk("r_ecc", tcdm.r_ecc, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wn, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] i);
    tcdm.req  = 1'b1;
    tcdm.wen  = wn;
    tcdm.add  = a;
    tcdm.data = d;
    tcdm.be   = b;
    tcdm.id   = i;
    tcdm.user = i[1:0];
  endtask

  task automatic issue(input logic wn, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] i, output int gcyc);
    drive(wn, a, d, b, i);
    gcyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tcdm.gnt === 1'b1) begin
        gcyc = cyc;
        tick();
        break;
      end
      tick();
    end
    tcdm.req = 1'b0;
    if (gcyc < 0) begin
      n_checks++;
      $display("FAIL grant_timeout: no gnt for add %0h within 50 cycles", a);
    end
  endtask

  task automatic wait_resp(input string name, input logic [31:0] exp_d, input logic [7:0] exp_i,
                           input int gcyc);
    bit seen;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (tcdm.r_valid === 1'b1) begin
        seen = 1;
        chk({name, "_data"}, tcdm.r_data, exp_d);
        chk({name, "_id"}, tcdm.r_id, exp_i);
        chk({name, "_latency"}, cyc - gcyc, 2);
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: r_valid never rose, required a response", name);
    end
    tick();
  endtask

  int          g;
  logic [31:0] r;

  initial begin
    rst_i         = 1'b1;
    tcdm.req      = 1'b0;
    tcdm.wen      = 1'b0;
    tcdm.add      = '0;
    tcdm.data     = '0;
    tcdm.be       = '0;
    tcdm.id       = '0;
    tcdm.user     = '0;
    tcdm.r_ready  = 1'b1;
    tcdm.ecc      = '0;
    tcdm.ereq     = '0;
    tcdm.r_eready = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_r_valid", tcdm.r_valid, 0);
    chk("reset_outstanding", outstanding, 0);
    tick();

    // Single read
    issue(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, g);
    issue(1'b1, 32'h10, 32'h0, 4'h0, 8'd3, g);
    wait_resp("single_read", 32'hDEADBEEF, 8'd3, g);

    // Byte enables
    issue(1'b0, 32'h20, 32'h11223344, 4'hF, 8'd0, g);
    issue(1'b0, 32'h20, 32'hAABBCCDD, 4'h5, 8'd0, g);
    issue(1'b1, 32'h20, 32'h0, 4'h0, 8'd5, g);
    wait_resp("byte_enable", 32'h11BB33DD, 8'd5, g);

    // Address wrap
    issue(1'b0, 32'h1000, 32'hCAFE0001, 4'hF, 8'd0, g);
    issue(1'b1, 32'h0, 32'h0, 4'h0, 8'd7, g);
    wait_resp("wrap_add0", 32'hCAFE0001, 8'd7, g);
    issue(1'b1, 32'h3, 32'h0, 4'h0, 8'd8, g);
    wait_resp("wrap_add3", 32'hCAFE0001, 8'd8, g);

    // Backpressure: six reads with r_ready low
    for (int k = 0; k < 6; k++) issue(1'b0, 32'h40 + 4*k, 32'h10000000 + k, 4'hF, 8'd0, g);
    tcdm.r_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40 + 4*k, 32'h0, 4'h0, 8'(k));
      @(negedge clk);
      chk("bp_gnt_first4", tcdm.gnt, 1);
      tick();
    end
    drive(1'b1, 32'h50, 32'h0, 4'h0, 8'd4);
    @(negedge clk);
    chk("bp_5th_gnt_low", tcdm.gnt, 0);
    chk("bp_full_outstanding", outstanding, 4);
    tick();
    tcdm.r_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_same_cycle_credit", tcdm.gnt, 0);
    chk("bp_head_data", tcdm.r_data, 32'h10000000);
    chk("bp_head_id", tcdm.r_id, 0);
    tick();
    @(negedge clk);
    chk("bp_5th_gnt_after_pop", tcdm.gnt, 1);
    tick();
    issue(1'b1, 32'h54, 32'h0, 4'h0, 8'd5, g);
    repeat (12) tick();

    // Reset with three reads outstanding
    tcdm.r_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(1'b1, 32'h40 + 4*k, 32'h0, 4'h0, 8'(k), g);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_r_valid", tcdm.r_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    tick();
    tcdm.r_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_no_late_resp", tcdm.r_valid, 0);
      tick();
    end
    issue(1'b1, 32'h40, 32'h0, 4'h0, 8'd9, g);
    wait_resp("rst_retained", 32'h10000000, 8'd9, g);

    // Random traffic over 16 words with random upper/offset address bits
    for (int k = 0; k < 16; k++) issue(1'b0, 32'h4 * k, $urandom, 4'hF, 8'd0, g);
    for (int k = 0; k < 10000; k++) begin
      r = $urandom;
      tcdm.req     = ($urandom % 4) != 0;
      tcdm.wen     = ($urandom % 2) != 0;
      tcdm.add     = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      tcdm.data    = $urandom;
      tcdm.be      = 4'($urandom_range(0, 15));
      tcdm.id      = 8'($urandom_range(0, 255));
      tcdm.user    = 2'($urandom_range(0, 3));
      tcdm.r_ready = ($urandom % 3) != 0;
      tick();
    end
    tcdm.req     = 1'b0;
    tcdm.r_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("drained_outstanding", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
